// File: rtl/config_loader.sv
// rtl/config_loader.sv - serializes host config words LSB-first into the config_tile shift chain
module config_loader #(
    parameter int WORD_W    = 8,
    parameter int NUM_TILES = 4,
    parameter int COMB_N    = 7,
    parameter int MEM_N     = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load_mem,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              cfg_shift_data,
    output logic              cfg_shift_en,
    output logic              cfg_mem_bypass,
    output logic              busy,
    output logic              done
);

    localparam int FULL_BITS = NUM_TILES * (COMB_N + MEM_N);
    localparam int BW        = $clog2(FULL_BITS + 1);
    localparam int IW        = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [BW-1:0] TOTAL_FULL = BW'(FULL_BITS);
    localparam logic [BW-1:0] TOTAL_COMB = BW'(NUM_TILES * COMB_N);
    localparam logic [IW-1:0] IDX_LAST   = IW'(WORD_W - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] word_q;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_inc;
    logic [BW-1:0]     bits_left;
    logic              load_mem_q;
    logic              data_q;
    logic              last_bit;
    logic              word_end;
    logic              hs;

    assign idx_inc        = idx + 1'b1;
    assign last_bit       = (bits_left == BW'(1));
    assign word_end       = (idx == IDX_LAST);
    assign hs             = in_valid & in_ready;
    assign cfg_shift_data = data_q;
    // Bypass follows the latched load mode, so it holds between loads and resets to 1.
    assign cfg_mem_bypass = ~load_mem_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = FETCH;
            FETCH: begin
                if (abort)   state_nxt = IDLE;
                else if (hs) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (abort)                 state_nxt = IDLE;
                else if (last_bit)         state_nxt = DONE;
                else if (word_end && !hs)  state_nxt = FETCH;
            end
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready     = 1'b0;
        cfg_shift_en = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            FETCH: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            SHIFT: begin
                cfg_shift_en = 1'b1;
                busy         = 1'b1;
                in_ready     = word_end & ~last_bit;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    // data_q is preloaded with the bit that will be on the chain during the next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q     <= '0;
            idx        <= '0;
            bits_left  <= '0;
            load_mem_q <= 1'b0;
            data_q     <= 1'b0;
        end else begin
            data_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        load_mem_q <= load_mem;
                        bits_left  <= load_mem ? TOTAL_FULL : TOTAL_COMB;
                    end
                end
                FETCH: begin
                    if (!abort && hs) begin
                        word_q <= in_data;
                        idx    <= '0;
                        data_q <= in_data[0];
                    end
                end
                SHIFT: begin
                    idx       <= idx_inc;
                    bits_left <= bits_left - 1'b1;
                    if (!abort && !last_bit) begin
                        if (!word_end) begin
                            data_q <= word_q[idx_inc];
                        end else if (hs) begin
                            word_q <= in_data;
                            idx    <= '0;
                            data_q <= in_data[0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - randomized self-checking bench for config_loader against a bit-list model
module tb_config_loader;

    localparam int WORD_W    = 8;
    localparam int NUM_TILES = 4;
    localparam int COMB_N    = 7;
    localparam int MEM_N     = 7;
    localparam int TOT_FULL  = NUM_TILES * (COMB_N + MEM_N);
    localparam int TOT_COMB  = NUM_TILES * COMB_N;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              load_mem = 1'b0;
    logic              abort = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WORD_W-1:0] in_data = '0;
    logic              cfg_shift_data;
    logic              cfg_shift_en;
    logic              cfg_mem_bypass;
    logic              busy;
    logic              done;

    config_loader #(
        .WORD_W(WORD_W), .NUM_TILES(NUM_TILES), .COMB_N(COMB_N), .MEM_N(MEM_N)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .load_mem(load_mem), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cfg_shift_data(cfg_shift_data), .cfg_shift_en(cfg_shift_en),
        .cfg_mem_bypass(cfg_mem_bypass), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [WORD_W-1:0] words [8];
    logic [63:0]       obs;
    int                n_shift, n_done, first_sc, last_sc, done_c, widx;
    bit                timed_out, busy_bad, data_bad, ready_late;

    // Reference: the chain sees the words concatenated LSB-first, cut to the load length.
    function automatic logic [63:0] exp_bits(input bit lm);
        logic [63:0] r;
        int          total;
        r = '0;
        total = lm ? TOT_FULL : TOT_COMB;
        for (int i = 0; i < total; i++) r[i] = words[i / WORD_W][i % WORD_W];
        return r;
    endfunction

    task automatic run_load(input bit lm, input int vpct, input int stall_word,
                            input int stall_len, input int abort_at, input int start_at);
        int cyc, post, stall_rem;
        bit ended, aborted, start_sent;
        obs = '0; n_shift = 0; n_done = 0; first_sc = -1; last_sc = -1; done_c = -1; widx = 0;
        timed_out = 0; busy_bad = 0; data_bad = 0; ready_late = 0;
        cyc = 0; post = 0; stall_rem = stall_len; ended = 0; aborted = 0; start_sent = 0;
        @(negedge clk);
        start = 1'b1; load_mem = lm; in_valid = 1'b0;
        while (1) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            if (cfg_shift_en) begin
                if (n_shift < 64) obs[n_shift] = cfg_shift_data;
                if (first_sc < 0) first_sc = cyc;
                last_sc = cyc;
                n_shift++;
            end else if (cfg_shift_data) begin
                data_bad = 1;
            end
            if (!ended && !busy) busy_bad = 1;
            if (ended && (busy || in_ready)) busy_bad = 1;
            if (done) begin
                n_done++;
                done_c = cyc;
                if (in_ready) ready_late = 1;
                ended = 1;
            end
            if (abort_at >= 0 && n_shift == abort_at && !aborted) begin
                abort = 1'b1;
                aborted = 1;
                ended = 1;
            end
            if (start_at >= 0 && n_shift == start_at && !start_sent) begin
                start = 1'b1;
                load_mem = ~lm;
                start_sent = 1;
            end
            if (widx == stall_word && in_ready && stall_rem > 0) begin
                in_valid = 1'b0;
                stall_rem--;
            end else begin
                in_valid = ($urandom_range(99) < vpct);
            end
            in_data = (widx < 8) ? words[widx] : WORD_W'($urandom);
            if (in_valid && in_ready) widx++;
            if (ended) post++;
            if (post > 4) break;
            if (cyc > 400) begin
                timed_out = 1;
                break;
            end
        end
        in_valid = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset;
        vectors++;
        if ({cfg_shift_en, cfg_shift_data, in_ready, busy, done, cfg_mem_bypass} !== 6'b000001) begin
            miscompares++;
            $display("FAIL reset_initial outputs=%b want 000001",
                     {cfg_shift_en, cfg_shift_data, in_ready, busy, done, cfg_mem_bypass});
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); start = 1'b1; load_mem = 1'b1;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
        repeat (10) @(negedge clk);
        vectors++;
        if (cfg_shift_en !== 1'b1 || cfg_mem_bypass !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pre_shift en=%b bypass=%b want 1 0", cfg_shift_en, cfg_mem_bypass);
        end
        @(posedge clk); #1 rst = 1'b0; #1;
        vectors++;
        if ({cfg_shift_en, cfg_shift_data, in_ready, busy, done, cfg_mem_bypass} !== 6'b000001) begin
            miscompares++;
            $display("FAIL reset_mid_shift outputs=%b want 000001",
                     {cfg_shift_en, cfg_shift_data, in_ready, busy, done, cfg_mem_bypass});
        end
        in_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_load;
        logic [7:0] pat [7];
        pat = '{8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h96, 8'h69, 8'h5A};
        for (int i = 0; i < 7; i++) words[i] = pat[i];
        words[7] = 8'hEE;
        run_load(1'b1, 100, -1, 0, -1, -1);
        vectors++;
        if (obs !== exp_bits(1'b1)) begin
            miscompares++; $display("FAIL full_bits got %h want %h", obs, exp_bits(1'b1));
        end
        vectors++;
        if (n_shift !== TOT_FULL || first_sc !== 2 || last_sc !== TOT_FULL + 1) begin
            miscompares++;
            $display("FAIL full_timing shifts=%0d first=%0d last=%0d want %0d 2 %0d",
                     n_shift, first_sc, last_sc, TOT_FULL, TOT_FULL + 1);
        end
        vectors++;
        if (n_done !== 1 || done_c !== last_sc + 1) begin
            miscompares++; $display("FAIL full_done count=%0d at=%0d want 1 at %0d", n_done, done_c, last_sc + 1);
        end
        vectors++;
        if (cfg_mem_bypass !== 1'b0 || widx !== 7 || busy_bad || data_bad || ready_late || timed_out) begin
            miscompares++;
            $display("FAIL full_misc bypass=%b words=%0d flags=%b%b%b%b want 0 7 0000",
                     cfg_mem_bypass, widx, busy_bad, data_bad, ready_late, timed_out);
        end
    endtask

    task automatic test_comb_only;
        for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
        run_load(1'b0, 100, -1, 0, -1, -1);
        vectors++;
        if (obs !== exp_bits(1'b0)) begin
            miscompares++; $display("FAIL comb_bits got %h want %h", obs, exp_bits(1'b0));
        end
        vectors++;
        if (n_shift !== TOT_COMB || last_sc - first_sc + 1 !== TOT_COMB || n_done !== 1 || done_c !== last_sc + 1) begin
            miscompares++;
            $display("FAIL comb_timing shifts=%0d span=%0d done=%0d want %0d %0d 1",
                     n_shift, last_sc - first_sc + 1, n_done, TOT_COMB, TOT_COMB);
        end
        vectors++;
        if (cfg_mem_bypass !== 1'b1 || widx !== 4 || ready_late || busy_bad || data_bad || timed_out) begin
            miscompares++;
            $display("FAIL comb_misc bypass=%b words=%0d flags=%b%b%b%b want 1 4 0000",
                     cfg_mem_bypass, widx, ready_late, busy_bad, data_bad, timed_out);
        end
    endtask

    task automatic test_stall;
        for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
        run_load(1'b1, 100, 2, 3, -1, -1);
        vectors++;
        if (obs !== exp_bits(1'b1) || n_shift !== TOT_FULL) begin
            miscompares++; $display("FAIL stall_bits got %h/%0d want %h/%0d", obs, n_shift, exp_bits(1'b1), TOT_FULL);
        end
        vectors++;
        if (last_sc - first_sc + 1 !== TOT_FULL + 3 || n_done !== 1 || done_c !== last_sc + 1) begin
            miscompares++;
            $display("FAIL stall_span span=%0d done=%0d want %0d 1", last_sc - first_sc + 1, n_done, TOT_FULL + 3);
        end
    endtask

    task automatic test_abort;
        for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
        run_load(1'b1, 100, -1, 0, 20, -1);
        vectors++;
        if (n_shift !== 20 || n_done !== 0 || busy_bad || timed_out) begin
            miscompares++;
            $display("FAIL abort_stop shifts=%0d done=%0d busy_bad=%b want 20 0 0", n_shift, n_done, busy_bad);
        end
        run_load(1'b1, 100, -1, 0, -1, -1);
        vectors++;
        if (obs !== exp_bits(1'b1) || n_shift !== TOT_FULL || n_done !== 1) begin
            miscompares++;
            $display("FAIL abort_reload got %h/%0d/%0d want %h/%0d/1", obs, n_shift, n_done, exp_bits(1'b1), TOT_FULL);
        end
    endtask

    task automatic test_start_during_shift;
        for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
        run_load(1'b1, 100, -1, 0, -1, 10);
        vectors++;
        if (obs !== exp_bits(1'b1) || n_shift !== TOT_FULL || n_done !== 1 || cfg_mem_bypass !== 1'b0) begin
            miscompares++;
            $display("FAIL start_ignored shifts=%0d done=%0d bypass=%b want %0d 1 0",
                     n_shift, n_done, cfg_mem_bypass, TOT_FULL);
        end
    endtask

    task automatic test_random;
        bit lm;
        int vpct;
        for (int k = 0; k < 6; k++) begin
            lm = 1'($urandom);
            vpct = $urandom_range(100, 30);
            for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
            run_load(lm, vpct, -1, 0, -1, -1);
            vectors++;
            if (obs !== exp_bits(lm) || n_shift !== (lm ? TOT_FULL : TOT_COMB)) begin
                miscompares++;
                $display("FAIL random_bits[%0d] got %h/%0d want %h/%0d", k, obs, n_shift,
                         exp_bits(lm), lm ? TOT_FULL : TOT_COMB);
            end
            vectors++;
            if (n_done !== 1 || done_c !== last_sc + 1 || cfg_mem_bypass !== ~lm ||
                widx !== ((lm ? TOT_FULL : TOT_COMB) + WORD_W - 1) / WORD_W ||
                busy_bad || data_bad || ready_late || timed_out) begin
                miscompares++;
                $display("FAIL random_ctrl[%0d] done=%0d bypass=%b words=%0d flags=%b%b%b%b",
                         k, n_done, cfg_mem_bypass, widx, busy_bad, data_bad, ready_late, timed_out);
            end
        end
    endtask

    initial begin
        #3;
        test_reset;
        test_full_load;
        test_comb_only;
        test_stall;
        test_abort;
        test_start_during_shift;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
